// File: rtl/frame_buffer_reader.sv
// Display-side reader of the camera frame-buffer controller: claims a buffer on
// each display frame start, streams burst read requests over the frame, then releases it.
module frame_buffer_reader #(
  parameter int FRAME_WIDTH     = 480,
  parameter int FRAME_HEIGHT    = 272,
  parameter int BURST_LEN       = 8,
  parameter int BUFFER_ID_WIDTH = 2,
  parameter int BUFFER_STRIDE   = 131072,
  parameter int ADDR_WIDTH      = 21
) (
  input  logic                       clk,
  input  logic                       reset_n,
  input  logic                       frame_start,
  output logic                       buf_req,
  input  logic                       buf_grant,
  input  logic [BUFFER_ID_WIDTH-1:0] buf_id,
  output logic                       buf_release,
  output logic [BUFFER_ID_WIDTH-1:0] cur_buf_id,
  input  logic [15:0]                fifo_space,
  output logic                       rd_req,
  output logic [ADDR_WIDTH-1:0]      rd_addr,
  input  logic                       rd_ack,
  output logic                       busy,
  output logic                       frame_overrun
);

  localparam int FRAME_WORDS = FRAME_WIDTH * FRAME_HEIGHT;
  localparam int OFS_W       = $clog2(FRAME_WORDS + 1);
  localparam logic [ADDR_WIDTH-1:0] STRIDE_ADDR = ADDR_WIDTH'(BUFFER_STRIDE);

  if (FRAME_WORDS % BURST_LEN != 0) begin : g_bad_burst_len
    $error("frame_buffer_reader: FRAME_WIDTH*FRAME_HEIGHT is not a multiple of BURST_LEN");
  end

  typedef enum logic [1:0] {IDLE, REQUEST, READING, RELEASE} state_t;

  state_t                state, state_nxt;
  logic                  pending;
  logic [OFS_W-1:0]      offset;
  logic [OFS_W-1:0]      offset_nxt;
  logic [ADDR_WIDTH-1:0] base;
  logic                  grant_ok, ack_ok, fifo_ok, last_burst;

  // Grants and acks only count when the matching request is actually up.
  assign grant_ok   = (state == REQUEST) && buf_req && buf_grant;
  assign ack_ok     = (state == READING) && rd_req && rd_ack;
  assign fifo_ok    = fifo_space >= 16'(BURST_LEN);
  assign offset_nxt = offset + OFS_W'(BURST_LEN);
  assign last_burst = offset_nxt == OFS_W'(FRAME_WORDS);

  assign buf_release = (state == RELEASE);
  assign busy        = (state != IDLE);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_nxt;
  end

  always_comb begin
    // NOTE: default assigned first so no path through the case leaves state_nxt unassigned (no latch).
    state_nxt = state;
    case (state)
      IDLE:    if (frame_start || pending) state_nxt = REQUEST;
      REQUEST: if (grant_ok)               state_nxt = READING;
      READING: if (ack_ok && last_burst)   state_nxt = RELEASE;
      RELEASE:                             state_nxt = IDLE;
      default:                             state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      buf_req       <= 1'b0;
      cur_buf_id    <= '0;
      base          <= '0;
      offset        <= '0;
      rd_req        <= 1'b0;
      rd_addr       <= '0;
      pending       <= 1'b0;
      frame_overrun <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every register samples pre-edge values of the others.
      frame_overrun <= (state == READING) && frame_start;

      // A frame start that lands on the release cycle is remembered, not dropped.
      if (state == IDLE)                          pending <= 1'b0;
      else if (state == RELEASE && frame_start)   pending <= 1'b1;

      case (state)
        REQUEST: begin
          if (grant_ok) begin
            cur_buf_id <= buf_id;
            base       <= ADDR_WIDTH'(buf_id) * STRIDE_ADDR;
            offset     <= '0;
            buf_req    <= 1'b0;
          end else begin
            buf_req    <= 1'b1;
          end
        end
        READING: begin
          if (ack_ok) begin
            rd_req <= 1'b0;
            offset <= offset_nxt;
          end else if (!rd_req && fifo_ok) begin
            rd_req  <= 1'b1;
            rd_addr <= base + ADDR_WIDTH'(offset);
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_frame_buffer_reader.sv
// Directed bench for frame_buffer_reader: small 4x2 frame, burst of 4, plus a
// second instance with stride 100 to exercise base-address wrap.
module tb_frame_buffer_reader;

  logic       clk = 1'b0;
  logic       reset_n;
  logic       frame_start;
  logic       buf_grant;
  logic [1:0] buf_id;
  logic [15:0] fifo_space;
  logic       rd_ack;

  logic       buf_req, buf_release, rd_req, busy, frame_overrun;
  logic [1:0] cur_buf_id;
  logic [7:0] rd_addr;

  logic       buf_req6, buf_release6, rd_req6, busy6, frame_overrun6;
  logic [1:0] cur_buf_id6;
  logic [7:0] rd_addr6;

  int vectors    = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  frame_buffer_reader #(
    .FRAME_WIDTH(4), .FRAME_HEIGHT(2), .BURST_LEN(4),
    .BUFFER_ID_WIDTH(2), .BUFFER_STRIDE(16), .ADDR_WIDTH(8)
  ) dut (
    .clk(clk), .reset_n(reset_n), .frame_start(frame_start),
    .buf_req(buf_req), .buf_grant(buf_grant), .buf_id(buf_id),
    .buf_release(buf_release), .cur_buf_id(cur_buf_id),
    .fifo_space(fifo_space), .rd_req(rd_req), .rd_addr(rd_addr),
    .rd_ack(rd_ack), .busy(busy), .frame_overrun(frame_overrun)
  );

  frame_buffer_reader #(
    .FRAME_WIDTH(4), .FRAME_HEIGHT(2), .BURST_LEN(4),
    .BUFFER_ID_WIDTH(2), .BUFFER_STRIDE(100), .ADDR_WIDTH(8)
  ) dut6 (
    .clk(clk), .reset_n(reset_n), .frame_start(frame_start),
    .buf_req(buf_req6), .buf_grant(buf_grant), .buf_id(buf_id),
    .buf_release(buf_release6), .cur_buf_id(cur_buf_id6),
    .fifo_space(fifo_space), .rd_req(rd_req6), .rd_addr(rd_addr6),
    .rd_ack(rd_ack), .busy(busy6), .frame_overrun(frame_overrun6)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Pulse frame_start from IDLE; REQUEST is entered with buf_req still low.
  task automatic start_frame(input string tag);
    frame_start = 1'b1;
    tick();
    frame_start = 1'b0;
    check({tag, "_busy"},       32'(busy), 32'd1);
    check({tag, "_req_entry"},  32'(buf_req), 32'd0);
  endtask

  // Wait for buf_req, let it sit for a cycle, then grant buffer id for one cycle.
  task automatic grant(input string tag, input logic [1:0] id);
    int n = 0;
    while (!buf_req && n < 20) begin
      tick();
      n++;
    end
    check({tag, "_buf_req"}, 32'(buf_req), 32'd1);
    tick();
    buf_grant = 1'b1;
    buf_id    = id;
    tick();
    buf_grant = 1'b0;
    check({tag, "_cur_id"},   32'(cur_buf_id), 32'(id));
    check({tag, "_req_drop"}, 32'(buf_req), 32'd0);
  endtask

  // Wait for a request, check its address and that it holds for `hold` cycles, then ack.
  task automatic burst(input string tag, input logic [7:0] addr, input int hold);
    int n = 0;
    while (!rd_req && n < 20) begin
      tick();
      n++;
    end
    check({tag, "_rd_req"},  32'(rd_req), 32'd1);
    check({tag, "_rd_addr"}, 32'(rd_addr), 32'(addr));
    for (int i = 0; i < hold; i++) begin
      tick();
      check({tag, "_hold_req"},  32'(rd_req), 32'd1);
      check({tag, "_hold_addr"}, 32'(rd_addr), 32'(addr));
    end
    rd_ack = 1'b1;
    tick();
    rd_ack = 1'b0;
    check({tag, "_req_drop"}, 32'(rd_req), 32'd0);
  endtask

  // Called right after the last ack: RELEASE is visible now, IDLE one cycle later.
  task automatic expect_release(input string tag, input logic [1:0] id);
    check({tag, "_release"},    32'(buf_release), 32'd1);
    check({tag, "_rel_id"},     32'(cur_buf_id), 32'(id));
    check({tag, "_rel_no_req"}, 32'(buf_req), 32'd0);
    tick();
    check({tag, "_rel_pulse"},  32'(buf_release), 32'd0);
    check({tag, "_idle"},       32'(busy), 32'd0);
  endtask

  initial begin
    reset_n     = 1'b0;
    frame_start = 1'b0;
    buf_grant   = 1'b0;
    buf_id      = 2'd0;
    fifo_space  = 16'd100;
    rd_ack      = 1'b0;
    tick();
    tick();
    check("rst_buf_req",   32'(buf_req), 32'd0);
    check("rst_release",   32'(buf_release), 32'd0);
    check("rst_rd_req",    32'(rd_req), 32'd0);
    check("rst_rd_addr",   32'(rd_addr), 32'd0);
    check("rst_cur_id",    32'(cur_buf_id), 32'd0);
    check("rst_busy",      32'(busy), 32'd0);
    check("rst_overrun",   32'(frame_overrun), 32'd0);
    reset_n = 1'b1;
    tick();

    // 1: basic frame, buffer 2 -> addresses 32, 36, then release.
    start_frame("t1");
    grant("t1", 2'd2);
    check("t1_no_req_first", 32'(rd_req), 32'd0);
    burst("t1_b0", 8'd32, 1);
    burst("t1_b1", 8'd36, 1);
    expect_release("t1", 2'd2);

    // 2: slow ack, request and address must hold steady.
    start_frame("t2");
    grant("t2", 2'd2);
    burst("t2_b0", 8'd32, 5);
    burst("t2_b1", 8'd36, 1);
    expect_release("t2", 2'd2);

    // 3: FIFO throttle; 3 words free blocks, 4 allows, then dropping does not withdraw.
    fifo_space = 16'd3;
    start_frame("t3");
    grant("t3", 2'd2);
    for (int i = 0; i < 4; i++) begin
      tick();
      check("t3_throttled", 32'(rd_req), 32'd0);
    end
    fifo_space = 16'd4;
    tick();
    check("t3_req_at_4",  32'(rd_req), 32'd1);
    check("t3_addr_at_4", 32'(rd_addr), 32'd32);
    fifo_space = 16'd0;
    tick();
    check("t3_req_kept",  32'(rd_req), 32'd1);
    fifo_space = 16'd100;
    burst("t3_b0", 8'd32, 0);
    burst("t3_b1", 8'd36, 1);
    expect_release("t3", 2'd2);

    // 4: overrun mid-frame, then frame_start on the release cycle becomes pending.
    start_frame("t4");
    grant("t4", 2'd1);
    burst("t4_b0", 8'd16, 1);
    frame_start = 1'b1;
    tick();
    frame_start = 1'b0;
    check("t4_overrun",     32'(frame_overrun), 32'd1);
    tick();
    check("t4_overrun_end", 32'(frame_overrun), 32'd0);
    burst("t4_b1", 8'd20, 1);
    check("t4_release",     32'(buf_release), 32'd1);
    frame_start = 1'b1;
    tick();
    frame_start = 1'b0;
    check("t4_single_rel",  32'(buf_release), 32'd0);
    check("t4_idle",        32'(busy), 32'd0);
    check("t4_rel_overrun", 32'(frame_overrun), 32'd0);
    tick();
    check("t4_pend_request", 32'(busy), 32'd1);
    check("t4_pend_req_lo",  32'(buf_req), 32'd0);
    tick();
    check("t4_pend_req_hi",  32'(buf_req), 32'd1);

    // 5: async reset while the offset-4 request is outstanding.
    grant("t5", 2'd2);
    burst("t5_b0", 8'd32, 1);
    tick();
    check("t5_req_off4",  32'(rd_req), 32'd1);
    check("t5_addr_off4", 32'(rd_addr), 32'd36);
    #2;
    reset_n = 1'b0;
    #1;
    check("t5_rst_rd_req",  32'(rd_req), 32'd0);
    check("t5_rst_rd_addr", 32'(rd_addr), 32'd0);
    check("t5_rst_busy",    32'(busy), 32'd0);
    check("t5_rst_cur_id",  32'(cur_buf_id), 32'd0);
    check("t5_rst_buf_req", 32'(buf_req), 32'd0);
    tick();
    check("t5_rst_no_rel",  32'(buf_release), 32'd0);
    reset_n = 1'b1;
    tick();
    check("t5_post_no_rel", 32'(buf_release), 32'd0);
    check("t5_post_idle",   32'(busy), 32'd0);
    start_frame("t5r");
    grant("t5r", 2'd2);
    burst("t5r_b0", 8'd32, 1);
    burst("t5r_b1", 8'd36, 1);
    expect_release("t5r", 2'd2);

    // 6: buffer 3; stride 16 gives base 48, stride 100 wraps 300 to 44.
    start_frame("t6");
    grant("t6", 2'd3);
    tick();
    tick();
    check("t6_req",        32'(rd_req), 32'd1);
    check("t6_addr_s16",   32'(rd_addr), 32'd48);
    check("t6_req_s100",   32'(rd_req6), 32'd1);
    check("t6_addr_s100",  32'(rd_addr6), 32'd44);
    rd_ack = 1'b1;
    tick();
    rd_ack = 1'b0;
    tick();
    check("t6_addr2_s16",  32'(rd_addr), 32'd52);
    check("t6_addr2_s100", 32'(rd_addr6), 32'd48);
    rd_ack = 1'b1;
    tick();
    rd_ack = 1'b0;
    check("t6_rel_s16",    32'(buf_release), 32'd1);
    check("t6_rel_s100",   32'(buf_release6), 32'd1);
    check("t6_id_s100",    32'(cur_buf_id6), 32'd3);
    tick();
    check("t6_idle_s100",  32'(busy6), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
